arbitro_fifo: RTL and testbench

ARBITRO_FIFO -- requirements
Module: arbitro_fifo

---
 rtl/arbitro_fifo.sv | 266 ++++++++++++++++++++++++++
 tb/tb_arbitro_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_fifo.sv
// Sensor-frame UART bridge: parses 3-byte frames (header, data, CRC-8) into a FIFO
// readable over Avalon-MM, with a UART transmitter, sticky error flags and an irq.

module uart_rx #(parameter int CLKS_PER_BIT = 434) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic       done_o,
   output logic [7:0] data_o
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
   rx_state_t     state_q;
   logic          meta_q, sync_q, done_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RX_IDLE;
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         done_q <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (!sync_q) state_q <= RX_START;
            end
            RX_START: // a glitch shorter than half a bit is not a start bit
               if (cnt_q == CW'((CLKS_PER_BIT - 1) / 2)) begin
                  cnt_q   <= '0;
                  state_q <= sync_q ? RX_IDLE : RX_BITS;
               end else cnt_q <= cnt_q + 1'b1;
            RX_BITS:
               if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                  cnt_q   <= '0;
                  shift_q <= {sync_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end else cnt_q <= cnt_q + 1'b1;
            RX_STOP:
               if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                  cnt_q   <= '0;
                  state_q <= RX_IDLE;
                  done_q  <= sync_q;
               end else cnt_q <= cnt_q + 1'b1;
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign done_o = done_q;
   assign data_o = shift_q;
endmodule

module uart_tx #(parameter int CLKS_PER_BIT = 434) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       done_o
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   tx_state_t     state_q;
   logic [8:0]    shift_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    bit_q;
   logic          tx_q, done_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= TX_IDLE;
         shift_q <= '1;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            TX_IDLE:
               if (start_i) begin
                  shift_q <= {1'b1, data_i};
                  tx_q    <= 1'b0;
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= TX_SEND;
               end
            TX_SEND:
               if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                  cnt_q <= '0;
                  if (bit_q == 4'd9) begin
                     state_q <= TX_IDLE;
                     tx_q    <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b1, shift_q[8:1]};
                  end
               end else cnt_q <= cnt_q + 1'b1;
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx_o   = tx_q;
   assign done_o = done_q;
endmodule

module arbitro_fifo #(
   parameter int CLKS_PER_BIT  = 434,
   parameter int DEPTH         = 16,
   parameter int FRAME_TIMEOUT = 8680
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [1:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq,
   output logic [1:0]  parser_state_o
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;
   localparam int TW   = $clog2(FRAME_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA} parse_state_t;
   parse_state_t  state_q;
   logic [2:0]    sensor_q;
   logic [7:0]    data_q;
   logic [TW-1:0] tmo_cnt_q;
   logic [11:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0] count_q;
   logic          overflow_q, timeout_q, tx_busy_q, tx_drop_q, irq_q;
   logic [1:0]    irq_en_q;

   logic          rx_done, tx_done, empty, full, pop, flush, frame_done;
   logic          push_ok, push_drop, tmo_hit, tx_start, tx_reject, status_wr;
   logic [7:0]    rx_byte, crc_calc, count8;
   logic [11:0]   push_entry;
   logic          unused_wdata;

   function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] b);
      logic [7:0] c;
      c = crc_in ^ b;
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk_i(clock), .rst_i(reset), .rx_i(rx), .done_o(rx_done), .data_o(rx_byte));
   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk_i(clock), .rst_i(reset), .start_i(tx_start), .data_i(writedata[7:0]),
      .tx_o(tx), .done_o(tx_done));

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNTW'(DEPTH));
   assign count8     = 8'(count_q);
   assign pop        = chipselect && read && (address == 2'd0) && !empty;
   assign status_wr  = chipselect && write && (address == 2'd1);
   assign flush      = status_wr && writedata[31];
   assign tx_start   = chipselect && write && (address == 2'd2) && !tx_busy_q;
   assign tx_reject  = chipselect && write && (address == 2'd2) && tx_busy_q;
   assign frame_done = rx_done && (state_q == DATA);
   assign crc_calc   = crc8_byte(crc8_byte(8'h00, {5'b10101, sensor_q}), data_q);
   assign push_entry = {rx_byte != crc_calc, sensor_q, data_q};
   // Flush wins over a completing frame; a full FIFO drops even if popped this cycle.
   assign push_ok    = frame_done && !flush && !full;
   assign push_drop  = frame_done && !flush && full;
   assign tmo_hit    = (state_q != IDLE) && !rx_done && !flush &&
                       (tmo_cnt_q == TW'(FRAME_TIMEOUT - 1));
   assign unused_wdata = ^{writedata[30:14], writedata[12], writedata[9:8]};

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: if (!empty) readdata = {19'b0, 1'b1, mem_q[rd_ptr_q]};
         2'd1: readdata = {18'b0, tx_drop_q, tx_busy_q, timeout_q, overflow_q, full, empty, count8};
         2'd2: readdata = {31'b0, tx_busy_q};
         default: readdata = {30'b0, irq_en_q};
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset && push_ok) mem_q[wr_ptr_q] <= push_entry;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         sensor_q   <= '0;
         data_q     <= '0;
         tmo_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_drop_q  <= 1'b0;
         irq_en_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         if (flush) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
         end else if (rx_done) begin
            tmo_cnt_q <= '0;
            case (state_q)
               IDLE: if (rx_byte[7:3] == 5'b10101) begin
                  sensor_q <= rx_byte[2:0];
                  state_q  <= HDR;
               end
               HDR: begin
                  data_q  <= rx_byte;
                  state_q <= DATA;
               end
               default: state_q <= IDLE;
            endcase
         end else if (state_q != IDLE) begin
            if (tmo_hit) begin
               state_q   <= IDLE;
               tmo_cnt_q <= '0;
            end else tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end

         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
         end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNTW'(push_ok) - CNTW'(pop);
         end

         overflow_q <= (overflow_q && !(status_wr && writedata[10])) || push_drop;
         timeout_q  <= (timeout_q  && !(status_wr && writedata[11])) || tmo_hit;
         tx_drop_q  <= (tx_drop_q  && !(status_wr && writedata[13])) || tx_reject;
         if (tx_start) tx_busy_q <= 1'b1;
         else if (tx_done) tx_busy_q <= 1'b0;
         if (chipselect && write && (address == 2'd3)) irq_en_q <= writedata[1:0];
         irq_q <= (irq_en_q[0] && !empty) || (irq_en_q[1] && (overflow_q || timeout_q));
      end
   end

   assign irq            = irq_q;
   assign parser_state_o = state_q;
endmodule

// File: tb/tb_arbitro_fifo.sv
// Directed and randomized frame traffic against a queue-based model of arbitro_fifo.

module tb_arbitro_fifo;
   localparam int CPB   = 8;
   localparam int DEPTH = 4;
   localparam int FT    = 200;
   localparam int W     = 12;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, rx = 1'b1;
   logic [1:0]  address = 2'd0;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        tx, irq;
   logic [1:0]  parser_state;

   arbitro_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .FRAME_TIMEOUT(FT)) dut (
      .clock(clock), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata), .rx(rx), .tx(tx),
      .irq(irq), .parser_state_o(parser_state));

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   logic m_ov = 1'b0, m_tmo = 1'b0, m_txdrop = 1'b0;

   initial begin
      #600000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // CRC as remainder of (header,data)*x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] crc_ref(input logic [7:0] h, input logic [7:0] d);
      logic [23:0] r;
      r = {h, d, 8'h00};
      for (int i = 23; i >= 8; i--) if (r[i]) r = r ^ (24'h107 << (i - 8));
      return r[7:0];
   endfunction

   function automatic logic [31:0] exp_status(input logic busy);
      logic [31:0] s;
      s = '0;
      s[7:0] = 8'(exp_q.size());
      s[8]   = (exp_q.size() == 0);
      s[9]   = (exp_q.size() == DEPTH);
      s[10]  = m_ov;
      s[11]  = m_tmo;
      s[12]  = busy;
      s[13]  = m_txdrop;
      return s;
   endfunction

   task automatic model_frame(input logic [7:0] h, input logic [7:0] d, input logic [7:0] c);
      if (exp_q.size() < DEPTH) exp_q.push_back({c != crc_ref(h, d), h[2:0], d});
      else m_ov = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_stop);
      @(negedge clock); rx = 1'b0;
      repeat (CPB - 1) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock); rx = b[i];
         repeat (CPB - 1) @(negedge clock);
      end
      @(negedge clock); rx = 1'b1;
      if (with_stop) repeat (CPB + 4) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] h, input logic [7:0] d, input logic [7:0] c);
      send_byte(h, 1); send_byte(d, 1); send_byte(c, 1);
      model_frame(h, d, c);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clock); chipselect = 1'b1; read = 1'b1; address = a;
      #1 d = readdata;
      @(negedge clock); chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
      @(negedge clock); chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
      @(negedge clock); chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic read_head(input string tag, output logic [31:0] d);
      logic [31:0] e;
      bus_read(2'd0, d);
      e = (exp_q.size() == 0) ? 32'd0 : {19'b0, 1'b1, exp_q.pop_front()};
      chk(tag, d, e);
   endtask

   task automatic chk_status(input string tag);
      logic [31:0] d;
      bus_read(2'd1, d);
      chk(tag, d, exp_status(1'b0));
   endtask

   function automatic logic [7:0] rand_hdr();
      return {5'b10101, 3'($urandom_range(0, 7))};
   endfunction

   initial begin
      logic [31:0] d;
      logic [7:0]  h, dat, c;
      logic [9:0]  txbits, exp_tx;
      int          n;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_tx", {31'b0, tx}, 32'd1);
      chk_status("rst_status");
      bus_read(2'd0, d); chk("rst_head", d, 32'd0);
      bus_read(2'd3, d); chk("rst_en", d, 32'd0);

      send_frame(8'hAB, 8'h59, 8'h07);
      chk_status("f1_status");
      read_head("f1_head", d); chk("f1_const", d, 32'h0000_1359);
      send_frame(8'hAB, 8'h59, 8'h00);
      send_frame(8'hAB, 8'h58, 8'h00);
      chk_status("f23_status");
      read_head("f2_head", d); chk("f2_const", d, 32'h0000_1B59);
      read_head("f3_head", d); chk("f3_const", d, 32'h0000_1358);
      read_head("empty_head", d);

      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            do h = 8'($urandom_range(0, 255)); while (h[7:3] == 5'b10101);
            send_byte(h, 1);
         end
         h   = rand_hdr();
         dat = 8'($urandom_range(0, 255));
         c   = ($urandom_range(0, 1) == 1) ? crc_ref(h, dat) : 8'($urandom_range(0, 255));
         send_frame(h, dat, c);
         if (k % 3 == 2) begin
            chk_status("rand_status");
            while (exp_q.size() > 0) read_head("rand_head", d);
         end
      end
      while (exp_q.size() > 0) read_head("rand_drain", d);

      for (int k = 0; k < DEPTH + 1; k++) begin
         h = rand_hdr(); dat = 8'($urandom_range(0, 255));
         send_frame(h, dat, crc_ref(h, dat));
      end
      chk_status("ovf_status");
      bus_write(2'd1, 32'h0000_0400); m_ov = 1'b0;
      chk_status("ovf_cleared");
      for (int k = 0; k < DEPTH; k++) read_head("ovf_head", d);
      read_head("ovf_empty", d);

      send_frame(8'hAB, 8'h33, 8'h00);
      bus_write(2'd1, 32'h8000_0000); exp_q.delete();
      chk_status("flush_status");

      send_byte(8'hAB, 1);
      repeat (FT + 60) @(negedge clock);
      m_tmo = 1'b1;
      chk_status("tmo_status");
      send_byte(8'h12, 1);
      h = rand_hdr(); dat = 8'($urandom_range(0, 255));
      send_frame(h, dat, crc_ref(h, dat));
      chk_status("tmo_next_status");
      read_head("tmo_next_head", d);

      bus_write(2'd3, 32'h0000_0002);
      bus_read(2'd3, d); chk("en_readback", d, 32'd2);
      @(negedge clock); chk("irq_err_on", {31'b0, irq}, 32'd1);
      bus_write(2'd1, 32'h0000_0800); m_tmo = 1'b0;
      @(negedge clock); chk("irq_err_off", {31'b0, irq}, 32'd0);

      bus_write(2'd3, 32'h0000_0001);
      h = rand_hdr(); dat = 8'($urandom_range(0, 255)); c = crc_ref(h, dat);
      @(negedge clock); chipselect = 1'b1; read = 1'b1; address = 2'd1;
      send_byte(h, 1); send_byte(dat, 1); send_byte(c, 0);
      n = -1;
      for (int i = 0; i < CPB + 8; i++) begin
         @(negedge clock); #1;
         if (n < 0 && readdata[7:0] == 8'd1) begin
            n = i;
            chk("irq_at_push", {31'b0, irq}, 32'd0);
            @(negedge clock);
            chk("irq_after_push", {31'b0, irq}, 32'd1);
         end
      end
      chk("push_seen", {31'b0, n >= 0}, 32'd1);
      model_frame(h, dat, c);
      address = 2'd0;
      #1 d = readdata;
      chk("irq_pop_head", d, {19'b0, 1'b1, exp_q.pop_front()});
      @(negedge clock); chipselect = 1'b0; read = 1'b0;
      #1 chk("irq_at_pop", {31'b0, irq}, 32'd1);
      @(negedge clock); chk("irq_after_pop", {31'b0, irq}, 32'd0);
      chk_status("irq_status");

      exp_tx = {1'b1, 8'h55, 1'b0};
      txbits = '0;
      @(negedge clock); chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h55;
      for (int i = 0; i < 10 * CPB; i++) begin
         @(negedge clock);
         if (i % CPB == CPB / 2) txbits[i / CPB] = tx;
         if (i == 0) writedata = 32'hAA;
         if (i == 1) begin
            write = 1'b0; read = 1'b1; address = 2'd1; m_txdrop = 1'b1;
            #1 chk("tx_busy_status", readdata, exp_status(1'b1));
         end
         if (i == 2) begin
            address = 2'd2;
            #1 chk("tx_busy_reg", readdata, 32'd1);
         end
         if (i == 3) begin chipselect = 1'b0; read = 1'b0; end
      end
      chk("tx_frame", {22'b0, txbits}, {22'b0, exp_tx});
      chipselect = 1'b1; read = 1'b1; address = 2'd2;
      n = 0;
      while (n < 20 && readdata[0] !== 1'b0) begin @(negedge clock); #1; n++; end
      chk("tx_busy_clear", {31'b0, readdata[0]}, 32'd0);
      chk("tx_idle_line", {31'b0, tx}, 32'd1);
      @(negedge clock); chipselect = 1'b0; read = 1'b0;
      bus_write(2'd1, 32'h0000_2000); m_txdrop = 1'b0;
      chk_status("txdrop_cleared");

      bus_write(2'd3, 32'h0000_0001);
      h = rand_hdr(); dat = 8'($urandom_range(0, 255));
      send_frame(h, dat, crc_ref(h, dat));
      send_byte(8'hAB, 1); send_byte(8'h59, 1);
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0;
      exp_q.delete();
      chk("rst_mid_irq", {31'b0, irq}, 32'd0);
      chk_status("rst_mid_status");
      bus_read(2'd3, d); chk("rst_mid_en", d, 32'd0);
      send_byte(8'h07, 1);
      chk_status("rst_mid_lone_byte");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
